// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache between a CPU data port
// and a word-wide memory with a readM/writeM/ready handshake.
module cache_ctrl #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [WORD_SIZE-1:0] cpu_address,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic [WORD_SIZE-1:0] num_access,
    output logic [WORD_SIZE-1:0] num_miss
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
    localparam int LINE_W = WORD_SIZE - OFF_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                 state_q, state_d;
    logic [OFF_W-1:0]       beat_q, beat_d;
    logic [LINE_W-1:0]      fill_line_q, fill_line_d;
    logic [WORD_SIZE-1:0]   access_q, access_d;
    logic [WORD_SIZE-1:0]   miss_q, miss_d;
    logic [NUM_LINES-1:0]   valid_q;

    logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
    logic [WORD_SIZE-1:0]   data_mem [NUM_LINES*LINE_WORDS];

    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       req_idx;
    logic [IDX_W+OFF_W-1:0] req_word;
    logic [IDX_W-1:0]       fill_idx;
    logic [TAG_W-1:0]       fill_tag;
    logic                   hit;
    logic                   last_beat;
    logic                   fill_we;
    logic                   fill_done;
    logic                   wr_hit_we;
    logic                   miss_start;

    assign req_tag    = cpu_address[WORD_SIZE-1 -: TAG_W];
    assign req_idx    = cpu_address[OFF_W +: IDX_W];
    assign req_word   = cpu_address[IDX_W+OFF_W-1:0];
    assign fill_idx   = fill_line_q[IDX_W-1:0];
    assign fill_tag   = fill_line_q[LINE_W-1 -: TAG_W];
    assign hit        = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign last_beat  = (beat_q == OFF_W'(LINE_WORDS - 1));
    assign fill_we    = (state_q == FILL) && mem_ready;
    assign fill_done  = fill_we && last_beat;
    assign wr_hit_we  = (state_q == WRITE) && mem_ready && hit;
    assign miss_start = (state_q == IDLE) && !cpu_write && cpu_read && !hit;

    assign num_access = access_q;
    assign num_miss   = miss_q;

    // Memory strobes decode only from state_q so they cannot glitch on request inputs.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        fill_line_d = fill_line_q;
        access_d    = access_q;
        miss_d      = miss_q;
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        readM       = 1'b0;
        writeM      = 1'b0;
        address     = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (cpu_write) begin
                    state_d = WRITE;
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = data_mem[req_word];
                    end else begin
                        state_d     = FILL;
                        beat_d      = '0;
                        fill_line_d = cpu_address[WORD_SIZE-1:OFF_W];
                        miss_d      = miss_q + 1'b1;
                    end
                end
            end
            FILL: begin
                readM   = 1'b1;
                address = {fill_line_q, beat_q};
                if (mem_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) state_d = IDLE;
                end
            end
            WRITE: begin
                writeM    = 1'b1;
                address   = cpu_address;
                mem_wdata = cpu_wdata;
                if (mem_ready) begin
                    cpu_ready = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cpu_ready) access_d = access_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            fill_line_q <= '0;
            access_q    <= '0;
            miss_q      <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            fill_line_q <= fill_line_d;
            access_q    <= access_d;
            miss_q      <= miss_d;
            // A line being refilled is invalid until its last beat lands.
            if (miss_start) valid_q[req_idx] <= 1'b0;
            if (fill_done)  valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we)   data_mem[{fill_idx, beat_q}] <= mem_rdata;
        if (wr_hit_we) data_mem[req_word] <= cpu_wdata;
        if (fill_done) tag_mem[fill_idx] <= fill_tag;
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed vector table, reset-during-fill sequence,
// then random traffic against a line-level reference model.
module tb_cache_ctrl;

    localparam int LW = 4;
    localparam int NL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [15:0] cpu_address, cpu_wdata, cpu_rdata;
    logic        cpu_ready, readM, writeM;
    logic [15:0] address, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [15:0] num_access, num_miss;

    cache_ctrl #(.WORD_SIZE(16), .LINE_WORDS(LW), .NUM_LINES(NL)) dut (
        .clk(clk), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .readM(readM), .writeM(writeM),
        .address(address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .num_access(num_access), .num_miss(num_miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          wt;
        bit          fill;
        logic [15:0] rdata;
        logic [15:0] acc;
        logic [15:0] miss;
    } vec_t;

    vec_t        vecs[10];
    logic [15:0] mem [65536];
    int          model_line [NL];
    int          model_acc, model_miss;

    int          n_pass = 0;
    int          n_total = 0;
    int          txn_id = 0;

    logic [15:0] rd_q[$];
    int          rdm_cyc, wrm_cyc, wr_n, got_cycles;
    logic [15:0] wr_addr, wr_data, got_rdata;
    bit          overlap, done;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (txn %0d): got %h expected %h", nm, txn_id, got, exp);
    endtask

    // Drives one CPU request and plays memory with wt wait cycles per access.
    task automatic run_req(input bit wr, input logic [15:0] a, input logic [15:0] wd, input int wt);
        int wc;
        wc = 0; rd_q.delete(); rdm_cyc = 0; wrm_cyc = 0; wr_n = 0;
        overlap = 0; done = 0; got_cycles = 0; got_rdata = '0;
        cpu_read = !wr; cpu_write = wr; cpu_address = a; cpu_wdata = wd;
        for (int n = 0; n < 400 && !done; n++) begin
            #1;
            mem_ready = 1'b0;
            if (readM || writeM) begin
                if (wc == wt) begin
                    mem_ready = 1'b1;
                    wc = 0;
                    if (readM) mem_rdata = mem[address];
                end else begin
                    wc++;
                end
            end
            #1;
            if (readM && writeM) overlap = 1;
            if (readM) rdm_cyc++;
            if (writeM) wrm_cyc++;
            if (readM && mem_ready) rd_q.push_back(address);
            if (writeM && mem_ready) begin
                wr_n++; wr_addr = address; wr_data = mem_wdata;
                mem[address] = mem_wdata;
            end
            if (cpu_ready) begin
                got_rdata = cpu_rdata;
                got_cycles = n + 1;
                done = 1;
            end
            @(negedge clk);
        end
        cpu_read = 1'b0; cpu_write = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic check_txn(input bit wr, input logic [15:0] a, input logic [15:0] wd, input int wt,
                             input bit exp_fill, input logic [15:0] exp_rd,
                             input logic [15:0] exp_acc, input logic [15:0] exp_miss);
        int exp_lat;
        exp_lat = wr ? wt + 2 : (exp_fill ? LW * (wt + 1) + 2 : 1);
        run_req(wr, a, wd, wt);
        $display("txn %0d %s addr=%h wdata=%h wait=%0d lat=%0d rdata=%h acc=%0d miss=%0d",
                 txn_id, wr ? "WR" : "RD", a, wd, wt, got_cycles, got_rdata, num_access, num_miss);
        chk("completed", done, 1);
        chk("latency", got_cycles, exp_lat);
        chk("rw_overlap", overlap, 0);
        chk("readM_cycles", rdm_cyc, exp_fill ? LW * (wt + 1) : 0);
        chk("writeM_cycles", wrm_cyc, wr ? wt + 1 : 0);
        chk("mem_writes", wr_n, wr ? 1 : 0);
        if (exp_fill) begin
            chk("fill_beats", rd_q.size(), LW);
            foreach (rd_q[i]) chk("fill_addr", rd_q[i], (a & ~16'(LW - 1)) + 16'(i));
        end
        if (wr && wr_n > 0) begin
            chk("wr_addr", wr_addr, a);
            chk("wr_data", wr_data, wd);
        end
        if (!wr) chk("rdata", got_rdata, exp_rd);
        chk("num_access", num_access, exp_acc);
        chk("num_miss", num_miss, exp_miss);
        txn_id++;
    endtask

    // Cache as a set of resident line numbers; write-through keeps it equal to memory.
    task automatic model_clear();
        foreach (model_line[i]) model_line[i] = -1;
        model_acc = 0; model_miss = 0;
    endtask

    task automatic model_txn(input bit wr, input logic [15:0] a, input logic [15:0] wd, input int wt);
        int line, idx;
        bit miss;
        logic [15:0] exp_rd;
        line = int'(a) / LW;
        idx = line % NL;
        miss = !wr && (model_line[idx] != line);
        exp_rd = mem[a];
        model_acc++;
        if (miss) begin
            model_miss++;
            model_line[idx] = line;
        end
        check_txn(wr, a, wd, wt, miss, exp_rd, 16'(model_acc), 16'(model_miss));
    endtask

    initial begin
        vecs[0] = '{0, 16'h0012, 16'h0000, 1, 1, 16'h00A2, 16'd1,  16'd1};
        vecs[1] = '{0, 16'h0011, 16'h0000, 0, 0, 16'h00A1, 16'd2,  16'd1};
        vecs[2] = '{1, 16'h0013, 16'h5555, 2, 0, 16'h0000, 16'd3,  16'd1};
        vecs[3] = '{0, 16'h0013, 16'h0000, 0, 0, 16'h5555, 16'd4,  16'd1};
        vecs[4] = '{1, 16'h0040, 16'h1234, 0, 0, 16'h0000, 16'd5,  16'd1};
        vecs[5] = '{0, 16'h0040, 16'h0000, 0, 1, 16'h1234, 16'd6,  16'd2};
        vecs[6] = '{0, 16'h0012, 16'h0000, 1, 1, 16'h00A2, 16'd7,  16'd3};
        vecs[7] = '{0, 16'h0052, 16'h0000, 1, 1, 16'h00E2, 16'd8,  16'd4};
        vecs[8] = '{0, 16'h0012, 16'h0000, 0, 1, 16'h00A2, 16'd9,  16'd5};
        vecs[9] = '{0, 16'h0013, 16'h0000, 0, 0, 16'h5555, 16'd10, 16'd5};

        for (int i = 0; i < 65536; i++) mem[i] = 16'(i + 16'h0090);
        reset = 1'b1; cpu_read = 0; cpu_write = 0; cpu_address = '0; cpu_wdata = '0;
        mem_rdata = '0; mem_ready = 0;

        @(negedge clk); #1;
        chk("rst_readM", readM, 0);
        chk("rst_writeM", writeM, 0);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_address", address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_num_access", num_access, 0);
        chk("rst_num_miss", num_miss, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i])
            check_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wt,
                      vecs[i].fill, vecs[i].rdata, vecs[i].acc, vecs[i].miss);

        // Reset arriving after two beats of a fill
        cpu_read = 1'b1; cpu_address = 16'h0032;
        for (int k = 0; k < 3; k++) begin
            #1;
            mem_ready = readM;
            mem_rdata = mem[address];
            @(negedge clk);
        end
        chk("midfill_readM", readM, 1);
        reset = 1'b1; mem_ready = 1'b0;
        #1;
        chk("abort_readM", readM, 0);
        chk("abort_cpu_ready", cpu_ready, 0);
        chk("abort_address", address, 0);
        chk("abort_num_access", num_access, 0);
        chk("abort_num_miss", num_miss, 0);
        cpu_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        model_txn(0, 16'h0012, 16'h0000, 0);
        chk("refill_first_addr", rd_q.size() > 0 ? rd_q[0] : 16'hFFFF, 16'h0010);

        for (int t = 0; t < 150; t++) begin
            bit wr;
            wr = ($urandom_range(0, 9) < 3);
            model_txn(wr, 16'($urandom_range(0, 63)), 16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
